spi_ram_ctrl: RTL and testbench
===============================

Name: spi_ram_ctrl

Overview:
Parametrised successor to the SPI-slave single-port RAM. Decodes 2-bit-tagged command words from the SPI slave front end into a synchronous single-port memory. Adds separate write/read pointers, optional auto-increment, multi-word burst reads with a tx_valid/tx_ready handshake back to the SPI shifter, and a sticky range-error flag.

Parameters:
DATA_W, 8, memory word and payload width
ADDR_W, 8, pointer width; must be <= DATA_W
MEM_DEPTH, 256, number of words; must be <= 2**ADDR_W
BURST_W, 4, width of the burst-length field; must be <= DATA_W
AUTO_INC, 1, 1 = pointers post-increment after each write/read word; 0 = pointers hold

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
din  in  DATA_W+2  command word; din[DATA_W+1:DATA_W] = opcode, din[DATA_W-1:0] = payload
rx_valid  in  1  din valid this cycle
rx_ready  out  1  block can accept a command
dout  out  DATA_W  read data to SPI shifter
tx_valid  out  1  dout valid, held until accepted
tx_ready  in  1  SPI shifter accepts dout
err  out  1  sticky range error

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, remaining=0, dout=0, tx_valid=0, err=0, FSM=IDLE. rx_ready is 0 while rst is high. Memory contents are not reset.
- Command accepted when rx_valid && rx_ready at a rising edge. rx_valid without rx_ready is ignored, not queued.
- FSM states: IDLE (rx_ready=1, tx_valid=0) and SEND (rx_ready=0, tx_valid=1).
- Opcode 00, set write pointer:
  - a = payload[ADDR_W-1:0].
  - If a < MEM_DEPTH: wr_ptr <= a. Otherwise wr_ptr is unchanged and err <= 1.
- Opcode 01, write data: mem[wr_ptr] <= payload. If AUTO_INC: wr_ptr <= (wr_ptr==MEM_DEPTH-1) ? 0 : wr_ptr+1.
- Opcode 10, set read pointer: same rules as 00, applied to rd_ptr.
- Opcode 11, burst read:
  - Length L = payload[BURST_W-1:0]+1, range 1..2**BURST_W.
  - At the accepting edge: dout <= mem[rd_ptr]; rd_ptr advances if AUTO_INC (same wrap rule); remaining <= L-1; FSM -> SEND.
  - tx_valid is therefore high from the cycle after acceptance (latency 1).
- SEND behaviour:
  - dout and tx_valid are held stable while tx_ready=0.
  - On tx_valid && tx_ready with remaining>0: dout <= mem[rd_ptr], rd_ptr advances if AUTO_INC, remaining decrements. tx_valid stays 1, giving back-to-back words with no bubble.
  - On tx_valid && tx_ready with remaining==0: tx_valid <= 0, FSM -> IDLE. rx_ready is 1 in the following cycle.
- AUTO_INC=0: a burst returns mem[rd_ptr] L times.
- Pointer wrap: an increment from MEM_DEPTH-1 goes to 0 and does not set err.
- err is set only by an out-of-range 00/10 command and is cleared only by rst.
- Payload bits above ADDR_W (for 00/10) and above BURST_W (for 11) are ignored.
- The write path and read path never touch memory in the same cycle, because writes are only accepted in IDLE.
- rst asserted mid-burst: tx_valid drops asynchronously, the burst is abandoned and remaining is cleared.

Test Plan:
1. Write, then burst read:
   - Stimulus: rst pulse; 00 payload 0x10; 01 0xA5; 01 0x5A; 10 0x10; 11 payload 1; tx_ready held 1.
   - Required: tx_valid high for 2 consecutive cycles starting 1 cycle after the 11 command, with dout=0xA5 then 0x5A; rx_ready=0 during those 2 cycles and 1 afterwards.
2. Handshake stall:
   - Stimulus: same setup as 1, but tx_ready=0 for 5 cycles, then 1.
   - Required: dout=0xA5 and tx_valid=1 held for all 5 stall cycles; 0x5A follows only after the first accept; commands sent with rx_valid during SEND have no effect (check memory afterwards).
3. Wrap:
   - Stimulus: MEM_DEPTH=256; 00 0xFF; 01 0x11; 01 0x22; 10 0xFF; 11 payload 1.
   - Required: mem[255]=0x11, mem[0]=0x22; dout sequence 0x11, 0x22; err=0.
4. Range error:
   - Stimulus: MEM_DEPTH=200; 00 0x05; 00 0xC8; 01 0x77.
   - Required: err=1 after the 0xC8 command; mem[5]=0x77; err stays 1 until rst.
5. AUTO_INC=0:
   - Stimulus: 00 0x03; 01 0x01; 01 0x02; 10 0x03; 11 payload 2.
   - Required: mem[3]=0x02; dout=0x02 three times.
6. Reset mid-burst:
   - Stimulus: 11 payload 15 (16 words); assert rst after 3 words, asynchronously between clock edges.
   - Required: tx_valid=0, dout=0, err=0 immediately on rst; after release, rx_ready=1 and rd_ptr reads back from 0.

Source files
------------

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: decodes 2-bit-tagged command words from an SPI slave front end
// into a single-port memory. It has separate write and read pointers, optional
// auto-increment, burst reads with a valid/ready handshake, and a sticky range error.
//
// Ports:
//   clk, rst  - rising-edge clock, asynchronous active-high reset
//   din       - {opcode[1:0], payload[DATA_W-1:0]} command word
//   rx_valid  - din valid; accepted when rx_ready is also high
//   rx_ready  - block is idle and can take a command
//   dout      - burst read data toward the SPI shifter
//   tx_valid  - dout valid, held until tx_ready
//   tx_ready  - SPI shifter accepts dout
//   err       - sticky out-of-range pointer error
module spi_ram_ctrl #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned BURST_W   = 4,
  parameter int unsigned AUTO_INC  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              err
);

  localparam logic [1:0] OP_SET_WR = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_SET_RD = 2'b10;
  localparam logic [1:0] OP_BURST  = 2'b11;

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(MEM_DEPTH - 1);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t               state_q;
  logic [ADDR_W-1:0]    wr_ptr_q;
  logic [ADDR_W-1:0]    rd_ptr_q;
  logic [BURST_W-1:0]   rem_q;
  logic [DATA_W-1:0]    dout_q;
  logic                 tx_valid_q;
  logic                 err_q;

  logic [DATA_W-1:0]    mem [MEM_DEPTH];

  logic [1:0]           op;
  logic [DATA_W-1:0]    payload;
  logic [ADDR_W-1:0]    addr_arg;
  logic                 addr_ok;
  logic                 cmd_acc;

  assign op       = din[DATA_W+1:DATA_W];
  assign payload  = din[DATA_W-1:0];
  assign addr_arg = payload[ADDR_W-1:0];
  assign addr_ok  = ({1'b0, addr_arg} < DEPTH_L);
  assign cmd_acc  = rx_valid && rx_ready;

  // Ready only while idle and out of reset.
  assign rx_ready = (state_q == S_IDLE) && !rst;
  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign err      = err_q;

  // Pointer post-increment with wrap at the last implemented word.
  function automatic logic [ADDR_W-1:0] adv(input logic [ADDR_W-1:0] p);
    if (AUTO_INC == 0) return p;
    return (p == LAST_A) ? '0 : p + ADDR_W'(1);
  endfunction

  // Memory write port; writes only happen on commands accepted in IDLE.
  always_ff @(posedge clk) begin
    if (cmd_acc && (op == OP_WRITE)) mem[wr_ptr_q] <= payload;
  end

  // Command decode, pointers and burst-read FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rem_q      <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_acc) begin
            case (op)
              OP_SET_WR: begin
                if (addr_ok) wr_ptr_q <= addr_arg;
                else         err_q    <= 1'b1;
              end
              OP_WRITE: wr_ptr_q <= adv(wr_ptr_q);
              OP_SET_RD: begin
                if (addr_ok) rd_ptr_q <= addr_arg;
                else         err_q    <= 1'b1;
              end
              OP_BURST: begin
                dout_q     <= mem[rd_ptr_q];
                rd_ptr_q   <= adv(rd_ptr_q);
                rem_q      <= payload[BURST_W-1:0];
                tx_valid_q <= 1'b1;
                state_q    <= S_SEND;
              end
              default: ;
            endcase
          end
        end
        S_SEND: begin
          // Preload the next word on accept so words stream without a bubble.
          if (tx_ready) begin
            if (rem_q != '0) begin
              dout_q   <= mem[rd_ptr_q];
              rd_ptr_q <= adv(rd_ptr_q);
              rem_q    <= rem_q - BURST_W'(1);
            end else begin
              tx_valid_q <= 1'b0;
              state_q    <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: three instances (default, MEM_DEPTH=200, AUTO_INC=0)
// share one stimulus stream. Each is checked against its own abstract model of
// pointers, memory and error flag.
module tb_spi_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  din;
  logic        rx_valid;
  logic        tx_ready;
  logic [2:0]  rxr;
  logic [2:0]  txv;
  logic [2:0]  errv;
  logic [7:0]  dout_a [3];

  int total = 0;
  int bad   = 0;

  // Reference model, indexed by instance.
  int          depth [3] = '{256, 200, 256};
  bit          inc   [3] = '{1'b1, 1'b1, 1'b0};
  int          wp [3];
  int          rp [3];
  bit          merr [3];
  logic [7:0]  mmem [3][256];
  bit          mknown [3][256];
  logic [7:0]  expd [3][16];
  bit          expk [3][16];

  always #5 clk = ~clk;

  spi_ram_ctrl u_d256 (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid), .rx_ready(rxr[0]),
    .dout(dout_a[0]), .tx_valid(txv[0]), .tx_ready(tx_ready), .err(errv[0])
  );

  spi_ram_ctrl #(.MEM_DEPTH(200)) u_d200 (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid), .rx_ready(rxr[1]),
    .dout(dout_a[1]), .tx_valid(txv[1]), .tx_ready(tx_ready), .err(errv[1])
  );

  spi_ram_ctrl #(.AUTO_INC(0)) u_noinc (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid), .rx_ready(rxr[2]),
    .dout(dout_a[2]), .tx_valid(txv[2]), .tx_ready(tx_ready), .err(errv[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int nxt(input int c, input int p);
    if (!inc[c]) return p;
    return (p == depth[c] - 1) ? 0 : p + 1;
  endfunction

  function automatic logic [2:0] merr_v();
    return {merr[2], merr[1], merr[0]};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      wp[c] = 0;
      rp[c] = 0;
      merr[c] = 1'b0;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (rxr !== 3'b111 && n < 40) begin
      tick();
      n++;
    end
    chk("rx_ready_before_cmd", 32'(rxr), 32'h7);
  endtask

  // Issue one command; non-burst opcodes are applied to the model here.
  task automatic send_cmd(input logic [1:0] op, input logic [7:0] pl);
    wait_ready();
    din = {op, pl};
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      case (op)
        2'b00: if (int'(pl) < depth[c]) wp[c] = int'(pl); else merr[c] = 1'b1;
        2'b01: begin
          mmem[c][wp[c]] = pl;
          mknown[c][wp[c]] = 1'b1;
          wp[c] = nxt(c, wp[c]);
        end
        2'b10: if (int'(pl) < depth[c]) rp[c] = int'(pl); else merr[c] = 1'b1;
        default: ;
      endcase
    end
    if (op != 2'b11) chk("err_after_cmd", 32'(errv), 32'(merr_v()));
  endtask

  // Build the expected word list of a burst of len words for every instance.
  task automatic model_burst(input int len);
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < len; i++) begin
        expd[c][i] = mmem[c][rp[c]];
        expk[c][i] = mknown[c][rp[c]];
        rp[c] = nxt(c, rp[c]);
      end
    end
  endtask

  task automatic check_word(input int i);
    chk($sformatf("tx_valid_w%0d", i), 32'(txv), 32'h7);
    chk($sformatf("rx_ready_busy_w%0d", i), 32'(rxr), 32'h0);
    for (int c = 0; c < 3; c++)
      if (expk[c][i]) chk($sformatf("dout_i%0d_w%0d", c, i), 32'(dout_a[c]), 32'(expd[c][i]));
  endtask

  // Burst of len words; optional stall before each accept and ignored commands during SEND.
  task automatic burst(input int len, input int first_stall, input int max_stall, input bit poke);
    int s;
    model_burst(len);
    tx_ready = 1'b0;
    send_cmd(2'b11, 8'(len - 1));
    for (int i = 0; i < len; i++) begin
      s = (i == 0) ? first_stall : int'($urandom_range(0, max_stall));
      for (int k = 0; k < s; k++) begin
        check_word(i);
        if (poke) begin
          din = {2'b01, 8'hEE};
          rx_valid = 1'b1;
        end
        tick();
        rx_valid = 1'b0;
      end
      check_word(i);
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
    end
    chk("tx_valid_done", 32'(txv), 32'h0);
    chk("rx_ready_done", 32'(rxr), 32'h7);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_valid"}, 32'(txv), 32'h0);
    chk({tag, "_rx_ready"}, 32'(rxr), 32'h0);
    chk({tag, "_err"}, 32'(errv), 32'h0);
    for (int c = 0; c < 3; c++) chk($sformatf("%s_dout%0d", tag, c), 32'(dout_a[c]), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    din = '0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    for (int c = 0; c < 3; c++)
      for (int a = 0; a < 256; a++) mknown[c][a] = 1'b0;
    model_reset();

    // Reset state.
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rx_ready_after_reset", 32'(rxr), 32'h7);

    // Write then burst read, tx_ready held high.
    send_cmd(2'b00, 8'h10);
    send_cmd(2'b01, 8'hA5);
    send_cmd(2'b01, 8'h5A);
    send_cmd(2'b10, 8'h10);
    burst(2, 0, 0, 1'b0);

    // Handshake stall with ignored writes during SEND, then read back the poked address.
    send_cmd(2'b00, 8'h12);
    send_cmd(2'b01, 8'h33);
    send_cmd(2'b10, 8'h10);
    burst(2, 5, 0, 1'b1);
    send_cmd(2'b10, 8'h12);
    burst(1, 0, 0, 1'b0);

    // Pointer wrap at the top of a 256-word memory.
    send_cmd(2'b00, 8'hFF);
    send_cmd(2'b01, 8'h11);
    send_cmd(2'b01, 8'h22);
    send_cmd(2'b10, 8'hFF);
    burst(2, 0, 1, 1'b0);

    // Range error on the 200-word instance; the pointer keeps its previous value.
    send_cmd(2'b00, 8'h05);
    send_cmd(2'b00, 8'hC8);
    send_cmd(2'b01, 8'h77);
    send_cmd(2'b10, 8'h05);
    burst(1, 0, 0, 1'b0);
    chk("err_sticky", 32'(errv[1]), 32'h1);

    // Non-incrementing pointers: the burst repeats one word.
    send_cmd(2'b00, 8'h03);
    send_cmd(2'b01, 8'h01);
    send_cmd(2'b01, 8'h02);
    send_cmd(2'b10, 8'h03);
    burst(3, 0, 2, 1'b0);

    // Fill memory with random data, then random command traffic.
    send_cmd(2'b00, 8'h00);
    for (int a = 0; a < 256; a++) send_cmd(2'b01, 8'($urandom));
    for (int n = 0; n < 60; n++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      if (op == 2'b11) burst(int'($urandom_range(1, 16)), int'($urandom_range(0, 2)), 3, 1'($urandom));
      else send_cmd(op, 8'($urandom));
    end

    // Reset in the middle of a 16-word burst, between clock edges.
    send_cmd(2'b10, 8'h20);
    model_burst(16);
    send_cmd(2'b11, 8'h0F);
    for (int i = 0; i < 3; i++) begin
      check_word(i);
      tx_ready = 1'b1;
      tick();
    end
    tx_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("midburst_reset");
    model_reset();
    @(posedge clk);
    #4 rst = 1'b0;
    tick();
    chk("rx_ready_after_midburst", 32'(rxr), 32'h7);
    burst(2, 0, 1, 1'b0);
    chk("err_after_midburst", 32'(errv), 32'(merr_v()));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
